// File: rtl/bs_arbiter_pkg.sv
// Shared widths and FSM state encoding for the barrel-shifter arbiter.
package bs_arbiter_pkg;

  localparam int IWIDTH_DEF = 4;
  localparam int SWIDTH_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/bs_arbiter_rr_arb2.sv
// Combinational two-way round-robin: on a tie the requester that was not
// granted last wins; a lone request always wins.
module rr_arb2 (
  input  logic [1:0] REQ,
  input  logic       LAST,
  output logic [1:0] GNT
);

  always_comb begin
    GNT = 2'b00;
    if (REQ[0] && REQ[1]) begin
      GNT = LAST ? 2'b01 : 2'b10;
    end else if (REQ[0]) begin
      GNT = 2'b01;
    end else if (REQ[1]) begin
      GNT = 2'b10;
    end
  end

endmodule

// File: rtl/bs_arbiter.sv
// Two-requester scheduler that time-shares one external barrel shifter and
// returns each result on a valid/ready channel tagged with the owner ID.
module bs_arbiter
  import bs_arbiter_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int SWIDTH = SWIDTH_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_DIR,
  input  logic [SWIDTH-1:0] REQ0_AMT,
  input  logic [IWIDTH-1:0] REQ0_DATA,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_DIR,
  input  logic [SWIDTH-1:0] REQ1_AMT,
  input  logic [IWIDTH-1:0] REQ1_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [IWIDTH-1:0] RSP_DATA,
  output logic              BS_DIR,
  output logic [SWIDTH-1:0] BS_AMT,
  output logic [IWIDTH-1:0] BS_D_IN,
  input  logic [IWIDTH-1:0] BS_D_OUT
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                bs_dir_q, bs_dir_d;
  logic [SWIDTH-1:0]   bs_amt_q, bs_amt_d;
  logic [IWIDTH-1:0]   bs_din_q, bs_din_d;
  logic                rsp_id_q, rsp_id_d;
  logic [IWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          gnt;

  rr_arb2 u_rr_arb2 (
    .REQ  ({REQ1_VALID, REQ0_VALID}),
    .LAST (last_q),
    .GNT  (gnt)
  );

  // A grant only exists for a valid requester, so READY doubles as the handshake.
  assign REQ0_READY = (state_q == S_IDLE) && gnt[0];
  assign REQ1_READY = (state_q == S_IDLE) && gnt[1];
  assign RSP_VALID  = (state_q == S_RESP);
  assign RSP_ID     = rsp_id_q;
  assign RSP_DATA   = rsp_data_q;
  assign BS_DIR     = bs_dir_q;
  assign BS_AMT     = bs_amt_q;
  assign BS_D_IN    = bs_din_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    bs_dir_d   = bs_dir_q;
    bs_amt_d   = bs_amt_q;
    bs_din_d   = bs_din_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0_READY) begin
          bs_dir_d = REQ0_DIR;
          bs_amt_d = REQ0_AMT;
          bs_din_d = REQ0_DATA;
          rsp_id_d = 1'b0;
          state_d  = S_SHIFT;
        end else if (REQ1_READY) begin
          bs_dir_d = REQ1_DIR;
          bs_amt_d = REQ1_AMT;
          bs_din_d = REQ1_DATA;
          rsp_id_d = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        rsp_data_d = BS_D_OUT;
        state_d    = S_RESP;
      end
      S_RESP: begin
        // Fairness pointer moves only once the consumer has taken the result.
        if (RSP_READY) begin
          last_d  = rsp_id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      bs_dir_q   <= 1'b0;
      bs_amt_q   <= '0;
      bs_din_q   <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      bs_dir_q   <= bs_dir_d;
      bs_amt_q   <= bs_amt_d;
      bs_din_q   <= bs_din_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_bs_arbiter.sv
// Self-checking bench for bs_arbiter with a behavioural shifter attached to
// the BS_* port and a transaction-level reference model.
module tb_bs_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       REQ0_VALID, REQ0_READY, REQ0_DIR;
  logic [1:0] REQ0_AMT;
  logic [3:0] REQ0_DATA;
  logic       REQ1_VALID, REQ1_READY, REQ1_DIR;
  logic [1:0] REQ1_AMT;
  logic [3:0] REQ1_DATA;
  logic       RSP_VALID, RSP_READY, RSP_ID;
  logic [3:0] RSP_DATA;
  logic       BS_DIR;
  logic [1:0] BS_AMT;
  logic [3:0] BS_D_IN, BS_D_OUT;

  int errors = 0;
  int checks = 0;
  bit last_owner = 1'b1;

  always #5 CLK = ~CLK;

  always_comb BS_D_OUT = BS_DIR ? (BS_D_IN >> BS_AMT) : (BS_D_IN << BS_AMT);

  bs_arbiter #(.IWIDTH(4), .SWIDTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_DIR(REQ0_DIR),
    .REQ0_AMT(REQ0_AMT), .REQ0_DATA(REQ0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_DIR(REQ1_DIR),
    .REQ1_AMT(REQ1_AMT), .REQ1_DATA(REQ1_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .BS_DIR(BS_DIR), .BS_AMT(BS_AMT), .BS_D_IN(BS_D_IN), .BS_D_OUT(BS_D_OUT)
  );

  // Reference shift written as multiply/divide by a power of two.
  function automatic logic [3:0] exp_shift(input bit dir, input logic [1:0] amt, input logic [3:0] data);
    int p, v;
    p = 1;
    for (int k = 0; k < int'(amt); k++) p = p * 2;
    if (dir) v = int'(data) / p;
    else     v = (int'(data) * p) % 16;
    return 4'(v);
  endfunction

  task automatic set_req(input bit id, input bit v, input bit dir, input logic [1:0] amt, input logic [3:0] data);
    if (id == 1'b0) begin
      REQ0_VALID = v; REQ0_DIR = dir; REQ0_AMT = amt; REQ0_DATA = data;
    end else begin
      REQ1_VALID = v; REQ1_DIR = dir; REQ1_AMT = amt; REQ1_DATA = data;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    last_owner = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    RST_N = 1'b0;
    #1;
    checks++;
    if ({RSP_VALID, RSP_ID, RSP_DATA} !== 6'd0) begin
      errors++; $display("FAIL reset_rsp: got %b expected 000000", {RSP_VALID, RSP_ID, RSP_DATA});
    end
    checks++;
    if ({BS_DIR, BS_AMT, BS_D_IN} !== 7'd0) begin
      errors++; $display("FAIL reset_bs: got %b expected 0000000", {BS_DIR, BS_AMT, BS_D_IN});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY, RSP_VALID} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got %b expected 000", {REQ0_READY, REQ1_READY, RSP_VALID});
    end
  endtask

  task automatic run_op(input bit id, input bit dir, input logic [1:0] amt, input logic [3:0] data);
    logic [3:0] exp;
    exp = exp_shift(dir, amt, data);
    @(negedge CLK);
    set_req(id, 1'b1, dir, amt, data);
    set_req(~id, 1'b0, 1'b0, 2'd0, 4'd0);
    RSP_READY = 1'b1;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== (id ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL op_ready id%0d: got %b expected %b", id, {REQ1_READY, REQ0_READY}, (id ? 2'b10 : 2'b01));
    end
    @(negedge CLK);
    set_req(id, 1'b0, dir, amt, data);
    #1;
    checks++;
    if ({RSP_VALID, BS_DIR, BS_AMT, BS_D_IN} !== {1'b0, dir, amt, data}) begin
      errors++; $display("FAIL op_shift: got %b expected %b", {RSP_VALID, BS_DIR, BS_AMT, BS_D_IN}, {1'b0, dir, amt, data});
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({RSP_VALID, RSP_ID, RSP_DATA} !== {1'b1, id, exp}) begin
      errors++; $display("FAIL op_resp: got v=%b id=%b d=%b expected v=1 id=%b d=%b", RSP_VALID, RSP_ID, RSP_DATA, id, exp);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL op_done: got RSP_VALID=%b expected 0", RSP_VALID);
    end
    last_owner = id;
  endtask

  task automatic test_single();
    do_reset();
    run_op(1'b0, 1'b0, 2'd1, 4'b1011);
    run_op(1'b1, 1'b1, 2'd2, 4'b1011);
    run_op(1'b0, 1'b0, 2'd0, 4'b1001);
    run_op(1'b1, 1'b1, 2'd0, 4'b1001);
    run_op(1'b0, 1'b0, 2'd3, 4'b1111);
    run_op(1'b1, 1'b1, 2'd3, 4'b1000);
    for (int n = 0; n < 6; n++)
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_alternate();
    bit         gseq[8];
    bit         rseq[8];
    logic [3:0] gexp[8];
    logic [3:0] rdat[8];
    logic [3:0] x0, x1;
    logic [1:0] a0, a1;
    bit         d0, d1;
    int         ng, nr;
    ng = 0; nr = 0;
    do_reset();
    x0 = 4'($urandom_range(0, 15)); x1 = ~x0;
    a0 = 2'($urandom_range(0, 3));  a1 = 2'($urandom_range(0, 3));
    d0 = 1'($urandom_range(0, 1));  d1 = 1'($urandom_range(0, 1));
    for (int c = 0; c < 30 && (ng < 4 || nr < 4); c++) begin
      @(negedge CLK);
      set_req(1'b0, 1'b1, d0, a0, x0);
      set_req(1'b1, 1'b1, d1, a1, x1);
      RSP_READY = 1'b1;
      #1;
      if (RSP_VALID && nr < 8) begin
        rseq[nr] = RSP_ID; rdat[nr] = RSP_DATA; nr++;
      end
      if (REQ0_READY && ng < 8) begin
        gseq[ng] = 1'b0; gexp[ng] = exp_shift(d0, a0, x0); ng++;
        x0 = 4'($urandom_range(0, 15)); a0 = 2'($urandom_range(0, 3)); d0 = 1'($urandom_range(0, 1));
      end else if (REQ1_READY && ng < 8) begin
        gseq[ng] = 1'b1; gexp[ng] = exp_shift(d1, a1, x1); ng++;
        x1 = 4'($urandom_range(0, 15)); a1 = 2'($urandom_range(0, 3)); d1 = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (ng < 4 || nr < 4) begin
      errors++; $display("FAIL alt_count: got grants=%0d responses=%0d expected at least 4 each", ng, nr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < ng && gseq[i] !== 1'(i % 2)) begin
        errors++; $display("FAIL alt_grant[%0d]: got %0d expected %0d", i, gseq[i], i % 2);
      end
      checks++;
      if (i < nr && i < ng && {rseq[i], rdat[i]} !== {1'(i % 2), gexp[i]}) begin
        errors++; $display("FAIL alt_rsp[%0d]: got id=%0d d=%h expected id=%0d d=%h", i, rseq[i], rdat[i], i % 2, gexp[i]);
      end
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b0, 2'd3, 4'b0001);
    RSP_READY = 1'b0;
    #1;
    checks++;
    if (REQ0_READY !== 1'b1) begin
      errors++; $display("FAIL stall_hs: got REQ0_READY=%b expected 1", REQ0_READY);
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b1, 1'b1, 2'd1, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({RSP_VALID, RSP_ID, RSP_DATA, REQ0_READY, REQ1_READY} !== {1'b1, 1'b0, 4'b1000, 2'b00}) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b id=%b d=%b rdy=%b%b expected v=1 id=0 d=1000 rdy=00",
                           k, RSP_VALID, RSP_ID, RSP_DATA, REQ1_READY, REQ0_READY);
      end
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    #1;
    checks++;
    if ({RSP_VALID, REQ1_READY} !== 2'b10) begin
      errors++; $display("FAIL stall_release: got v=%b rdy1=%b expected v=1 rdy1=0", RSP_VALID, REQ1_READY);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({RSP_VALID, REQ1_READY} !== 2'b01) begin
      errors++; $display("FAIL stall_after: got v=%b rdy1=%b expected v=0 rdy1=1", RSP_VALID, REQ1_READY);
    end
    @(negedge CLK);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b0, 2'd1, 4'b1011);
    RSP_READY = 1'b1;
    #1;
    checks++;
    if (REQ0_READY !== 1'b1) begin
      errors++; $display("FAIL rmid_hs: got REQ0_READY=%b expected 1", REQ0_READY);
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    #1;
    checks++;
    if (BS_D_IN !== 4'b1011) begin
      errors++; $display("FAIL rmid_loaded: got BS_D_IN=%b expected 1011", BS_D_IN);
    end
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({RSP_VALID, RSP_ID, RSP_DATA, BS_DIR, BS_AMT, BS_D_IN, REQ0_READY, REQ1_READY} !== 15'd0) begin
      errors++; $display("FAIL rmid_async: got %b expected all zero",
                         {RSP_VALID, RSP_ID, RSP_DATA, BS_DIR, BS_AMT, BS_D_IN, REQ0_READY, REQ1_READY});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    last_owner = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (RSP_VALID !== 1'b0) begin
        errors++; $display("FAIL rmid_stale[%0d]: got RSP_VALID=%b expected 0", k, RSP_VALID);
      end
    end
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b1, 2'd1, 4'b0110);
    set_req(1'b1, 1'b1, 1'b0, 2'd1, 4'b0101);
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
      errors++; $display("FAIL rmid_tie: got %b expected 01", {REQ1_READY, REQ0_READY});
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  // Transaction-level model: one operation in flight from grant until its
  // response is accepted; response visible two cycles after the grant.
  task automatic test_random(input int ncyc);
    bit         v[2];
    bit         d[2];
    logic [1:0] a[2];
    logic [3:0] x[2];
    bit         busy, exp_id, w, any, er0, er1, erv;
    int         hs_c;
    logic [3:0] exp_data;
    logic [6:0] exp_bs;
    do_reset();
    v[0] = 0; v[1] = 0; busy = 0; hs_c = 0; exp_id = 0; exp_data = 0; exp_bs = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[i] = 1; d[i] = 1'($urandom_range(0, 1)); a[i] = 2'($urandom_range(0, 3)); x[i] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 9) == 0) begin
          v[i] = 0;
        end
        set_req(1'(i), v[i], d[i], a[i], x[i]);
      end
      RSP_READY = ($urandom_range(0, 3) != 0);
      #1;
      any = v[0] | v[1];
      w   = (v[0] && v[1]) ? ~last_owner : v[1];
      er0 = !busy && any && (w == 1'b0);
      er1 = !busy && any && (w == 1'b1);
      erv = busy && (c >= hs_c + 2);
      checks++;
      if ({REQ1_READY, REQ0_READY} !== {er1, er0}) begin
        errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, {REQ1_READY, REQ0_READY}, {er1, er0});
      end
      checks++;
      if (RSP_VALID !== erv) begin
        errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, RSP_VALID, erv);
      end
      if (erv) begin
        checks++;
        if ({RSP_ID, RSP_DATA} !== {exp_id, exp_data}) begin
          errors++; $display("FAIL rand_rsp c%0d: got id=%b d=%h expected id=%b d=%h", c, RSP_ID, RSP_DATA, exp_id, exp_data);
        end
      end
      if (busy && c > hs_c) begin
        checks++;
        if ({BS_DIR, BS_AMT, BS_D_IN} !== exp_bs) begin
          errors++; $display("FAIL rand_bs c%0d: got %b expected %b", c, {BS_DIR, BS_AMT, BS_D_IN}, exp_bs);
        end
      end
      if (erv && RSP_READY) begin
        busy = 0; last_owner = exp_id;
      end else if (!busy && any) begin
        busy = 1; hs_c = c; exp_id = w;
        exp_bs = {d[w], a[w], x[w]};
        exp_data = exp_shift(d[w], a[w], x[w]);
        v[w] = 0;
      end
    end
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    RSP_READY = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
